// File: rtl/qdr_cal_pkg.sv
// Shared types and helpers for the four-phase capture calibration controller.
// Holds the FSM encoding, phase codes and the eye-centre selection rule.
package qdr_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_NEXT    = 3'd3,
        ST_DECIDE  = 3'd4,
        ST_LOCKED  = 3'd5,
        ST_FAIL    = 3'd6
    } cal_state_t;

    localparam logic [1:0] PH_0   = 2'd0;
    localparam logic [1:0] PH_90  = 2'd1;
    localparam logic [1:0] PH_180 = 2'd2;
    localparam logic [1:0] PH_270 = 2'd3;

    // Counters are sized for the largest legal settle_cycles / sample_count.
    localparam int SETTLE_CNT_W = 8;
    localparam int SAMPLE_CNT_W = 16;

    // Returns {found, phase}. Prefers the lowest phase whose both neighbours
    // (mod 4) are also clean; otherwise the lowest clean phase.
    function automatic logic [2:0] pick_phase(input logic [3:0] mask);
        logic       found;
        logic [1:0] ph;
        logic [1:0] lo;
        logic [1:0] hi;
        found = 1'b0;
        ph    = PH_0;
        for (int p = 0; p < 4; p++) begin
            lo = 2'(p) - 2'd1;
            hi = 2'(p) + 2'd1;
            if (!found && mask[p] && mask[lo] && mask[hi]) begin
                found = 1'b1;
                ph    = 2'(p);
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (!found && mask[p]) begin
                found = 1'b1;
                ph    = 2'(p);
            end
        end
        return {found, ph};
    endfunction

endpackage

// File: rtl/qdr_pattern_check.sv
// Alternating training-pattern checker: every sample must be the pattern or its
// complement and must invert the previous sample. Error flag is sticky until clear.
module qdr_pattern_check
    import qdr_cal_pkg::*;
#(
    parameter int               width         = 8,
    parameter logic [width-1:0] train_pattern = 8'h55
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] sample,
    input  logic             enable,
    input  logic             clear,
    output logic             err
);

    logic [width-1:0] prev;
    logic             first;
    logic             bad_member;
    logic             bad_toggle;

    assign bad_member = (sample != train_pattern) && (sample != ~train_pattern);
    assign bad_toggle = !first && (sample != ~prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err   <= 1'b0;
            first <= 1'b1;
        end else if (clear) begin
            err   <= 1'b0;
            first <= 1'b1;
        end else if (enable) begin
            first <= 1'b0;
            if (bad_member || bad_toggle) begin
                err <= 1'b1;
            end
        end
    end

    // prev is only meaningful once first has dropped, so it needs no reset.
    always_ff @(posedge clk) begin
        if (enable) begin
            prev <= sample;
        end
    end

endmodule

// File: rtl/qdr_phase_cal.sv
// Four-phase ADC capture calibration: measures each phase against the training
// pattern, picks the eye-centre phase and steers it onto a registered output bus.
module qdr_phase_cal
    import qdr_cal_pkg::*;
#(
    parameter int               width         = 8,
    parameter logic [width-1:0] train_pattern = 8'h55,
    parameter int               settle_cycles = 4,
    parameter int               sample_count  = 256
) (
    input  logic             clk_0,
    input  logic             reset_n,
    input  logic [width-1:0] data0,
    input  logic [width-1:0] data90,
    input  logic [width-1:0] data180,
    input  logic [width-1:0] data270,
    input  logic             cal_start,
    output logic [width-1:0] data_out,
    output logic [1:0]       phase_sel,
    output logic [3:0]       valid_mask,
    output logic             busy,
    output logic             cal_done,
    output logic             cal_fail
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(settle_cycles - 1);
    localparam logic [SAMPLE_CNT_W-1:0] SAMPLE_LAST = SAMPLE_CNT_W'(sample_count - 1);

    logic [1:0]              rst_pipe;
    logic                    rst_n_int;

    cal_state_t              state, state_nxt;
    logic [1:0]              meas_phase, meas_phase_nxt;
    logic [3:0]              valid_mask_nxt;
    logic [1:0]              phase_sel_nxt;
    logic                    busy_nxt, cal_done_nxt, cal_fail_nxt;
    logic [SETTLE_CNT_W-1:0] settle_cnt, settle_cnt_nxt;
    logic [SAMPLE_CNT_W-1:0] sample_cnt, sample_cnt_nxt;
    logic                    chk_en, chk_clr, chk_err;
    logic [2:0]              pick;
    logic [width-1:0]        meas_sample;
    logic [width-1:0]        out_sample;

    // Assertion is immediate; release is delayed two clocks so every flop
    // below leaves reset on the same edge.
    always_ff @(posedge clk_0 or negedge reset_n) begin
        if (!reset_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end
    assign rst_n_int = rst_pipe[1];

    always_comb begin
        meas_sample = data0;
        case (meas_phase)
            PH_0:    meas_sample = data0;
            PH_90:   meas_sample = data90;
            PH_180:  meas_sample = data180;
            default: meas_sample = data270;
        endcase
    end

    always_comb begin
        out_sample = data0;
        case (phase_sel)
            PH_0:    out_sample = data0;
            PH_90:   out_sample = data90;
            PH_180:  out_sample = data180;
            default: out_sample = data270;
        endcase
    end

    qdr_pattern_check #(
        .width         (width),
        .train_pattern (train_pattern)
    ) u_check (
        .clk    (clk_0),
        .rst_n  (rst_n_int),
        .sample (meas_sample),
        .enable (chk_en),
        .clear  (chk_clr),
        .err    (chk_err)
    );

    assign pick = pick_phase(valid_mask);

    always_comb begin
        state_nxt      = state;
        meas_phase_nxt = meas_phase;
        valid_mask_nxt = valid_mask;
        phase_sel_nxt  = phase_sel;
        busy_nxt       = busy;
        cal_done_nxt   = cal_done;
        cal_fail_nxt   = cal_fail;
        settle_cnt_nxt = settle_cnt;
        sample_cnt_nxt = sample_cnt;
        chk_en         = 1'b0;
        chk_clr        = 1'b0;

        case (state)
            ST_IDLE, ST_LOCKED, ST_FAIL: begin
                if (cal_start) begin
                    state_nxt      = ST_SETTLE;
                    meas_phase_nxt = PH_0;
                    valid_mask_nxt = 4'b0000;
                    busy_nxt       = 1'b1;
                    cal_done_nxt   = 1'b0;
                    cal_fail_nxt   = 1'b0;
                    settle_cnt_nxt = '0;
                    sample_cnt_nxt = '0;
                end
            end
            ST_SETTLE: begin
                chk_clr = 1'b1;
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt      = ST_MEASURE;
                    settle_cnt_nxt = '0;
                    sample_cnt_nxt = '0;
                end else begin
                    settle_cnt_nxt = settle_cnt + 8'd1;
                end
            end
            ST_MEASURE: begin
                chk_en = 1'b1;
                if (sample_cnt == SAMPLE_LAST) begin
                    state_nxt      = ST_NEXT;
                    sample_cnt_nxt = '0;
                end else begin
                    sample_cnt_nxt = sample_cnt + 16'd1;
                end
            end
            ST_NEXT: begin
                valid_mask_nxt[meas_phase] = ~chk_err;
                if (meas_phase == PH_270) begin
                    state_nxt = ST_DECIDE;
                end else begin
                    meas_phase_nxt = meas_phase + 2'd1;
                    settle_cnt_nxt = '0;
                    state_nxt      = ST_SETTLE;
                end
            end
            ST_DECIDE: begin
                busy_nxt = 1'b0;
                if (pick[2]) begin
                    phase_sel_nxt = pick[1:0];
                    cal_done_nxt  = 1'b1;
                    state_nxt     = ST_LOCKED;
                end else begin
                    cal_fail_nxt  = 1'b1;
                    state_nxt     = ST_FAIL;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_0 or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state      <= ST_IDLE;
            meas_phase <= PH_0;
            valid_mask <= 4'b0000;
            phase_sel  <= PH_0;
            busy       <= 1'b0;
            cal_done   <= 1'b0;
            cal_fail   <= 1'b0;
            settle_cnt <= '0;
            sample_cnt <= '0;
        end else begin
            state      <= state_nxt;
            meas_phase <= meas_phase_nxt;
            valid_mask <= valid_mask_nxt;
            phase_sel  <= phase_sel_nxt;
            busy       <= busy_nxt;
            cal_done   <= cal_done_nxt;
            cal_fail   <= cal_fail_nxt;
            settle_cnt <= settle_cnt_nxt;
            sample_cnt <= sample_cnt_nxt;
        end
    end

    // Output stage: follows the committed phase in every state.
    always_ff @(posedge clk_0 or negedge rst_n_int) begin
        if (!rst_n_int) begin
            data_out <= '0;
        end else begin
            data_out <= out_sample;
        end
    end

endmodule

// File: tb/tb_qdr_phase_cal.sv
// Randomized bench for qdr_phase_cal: per-phase data streams are built up front and
// a window/alternation model derives the expected mask, phase and timing.
module tb_qdr_phase_cal;

    localparam int          S     = 4;
    localparam int          N     = 256;
    localparam int          PER   = S + N + 1;
    localparam int          TOTAL = 4 * PER + 1;
    localparam int          NCYC  = TOTAL + 3;
    localparam logic [7:0]  PAT   = 8'h55;
    localparam logic [7:0]  NPAT  = 8'hAA;

    logic       clk_0 = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data0 = '0, data90 = '0, data180 = '0, data270 = '0;
    logic       cal_start = 1'b0;
    logic [7:0] data_out;
    logic [1:0] phase_sel;
    logic [3:0] valid_mask;
    logic       busy, cal_done, cal_fail;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] arr [4][NCYC];
    int         typ  [4];
    logic [7:0] cval [4];
    int         cpos [4];
    logic [1:0] exp_sel = 2'd0;

    qdr_phase_cal dut (
        .clk_0      (clk_0),
        .reset_n    (reset_n),
        .data0      (data0),
        .data90     (data90),
        .data180    (data180),
        .data270    (data270),
        .cal_start  (cal_start),
        .data_out   (data_out),
        .phase_sel  (phase_sel),
        .valid_mask (valid_mask),
        .busy       (busy),
        .cal_done   (cal_done),
        .cal_fail   (cal_fail)
    );

    always #5 clk_0 = ~clk_0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int win_base(input int p);
        return 1 + p * PER + S;
    endfunction

    // typ: 0 clean, 1 one word replaced, 2 one word repeated, 3 stuck at zero
    task automatic build();
        int pol, b;
        for (int p = 0; p < 4; p++) begin
            pol = int'($urandom_range(0, 1));
            b   = win_base(p);
            for (int k = 0; k < NCYC; k++) arr[p][k] = 8'($urandom);
            if (typ[p] == 3) begin
                for (int k = 0; k < NCYC; k++) arr[p][k] = 8'h00;
            end else begin
                for (int i = 0; i < N; i++) arr[p][b+i] = (((i + pol) % 2) == 1) ? NPAT : PAT;
                if (typ[p] == 1) arr[p][b+cpos[p]] = cval[p];
                if (typ[p] == 2) arr[p][b+cpos[p]] = arr[p][b+cpos[p]-1];
            end
        end
    endtask

    function automatic logic [3:0] model_mask();
        logic [3:0] m;
        logic [7:0] s;
        int b;
        m = 4'b0000;
        for (int p = 0; p < 4; p++) begin
            b    = win_base(p);
            m[p] = 1'b1;
            for (int i = 0; i < N; i++) begin
                s = arr[p][b+i];
                if (s != PAT && s != NPAT) m[p] = 1'b0;
                if (i > 0 && s != ~arr[p][b+i-1]) m[p] = 1'b0;
            end
        end
        return m;
    endfunction

    task automatic drive(input int k);
        data0   = arr[0][k];
        data90  = arr[1][k];
        data180 = arr[2][k];
        data270 = arr[3][k];
    endtask

    // Runs one calibration from the cal_start edge (edge 0). abort_at >= 0 pulls
    // reset at that edge instead of finishing.
    task automatic run_cal(input string tag, input int abort_at);
        logic [3:0] m;
        logic       found;
        logic [1:0] new_sel, old_sel;
        int         extra, e;
        build();
        m     = model_mask();
        found = 1'b0;
        new_sel = exp_sel;
        for (int p = 0; p < 4; p++)
            if (!found && m[p] && m[(p+3)%4] && m[(p+1)%4]) begin found = 1'b1; new_sel = 2'(p); end
        for (int p = 0; p < 4; p++)
            if (!found && m[p]) begin found = 1'b1; new_sel = 2'(p); end
        old_sel = exp_sel;
        extra   = int'($urandom_range(5, 1000));

        @(negedge clk_0);
        drive(0);
        cal_start = 1'b1;
        for (int k = 1; k < NCYC; k++) begin
            @(negedge clk_0);
            e = k - 1;
            if (e == abort_at) begin
                #1 reset_n = 1'b0;
                #1;
                chk({tag, " rst data_out"}, 32'(data_out), 0);
                chk({tag, " rst phase_sel"}, 32'(phase_sel), 0);
                chk({tag, " rst valid_mask"}, 32'(valid_mask), 0);
                chk({tag, " rst flags"}, {busy, cal_done, cal_fail}, 0);
                cal_start = 1'b0;
                repeat (2) @(negedge clk_0);
                reset_n = 1'b1;
                repeat (3) @(negedge clk_0);
                exp_sel = 2'd0;
                return;
            end
            if (e == 0) begin
                chk({tag, " start busy"}, 32'(busy), 1);
                chk({tag, " start flags"}, {cal_done, cal_fail}, 0);
                chk({tag, " start mask"}, 32'(valid_mask), 0);
            end
            if (e == TOTAL - 1) begin
                chk({tag, " early done/fail"}, {cal_done, cal_fail}, 0);
                chk({tag, " still busy"}, 32'(busy), 1);
            end
            if (e == TOTAL) begin
                chk({tag, " mask"}, 32'(valid_mask), 32'(m));
                chk({tag, " done"}, 32'(cal_done), 32'(found));
                chk({tag, " fail"}, 32'(cal_fail), 32'(!found));
                chk({tag, " busy end"}, 32'(busy), 0);
                chk({tag, " phase_sel"}, 32'(phase_sel), 32'(new_sel));
            end
            if ((e % 131) == 7 || e == TOTAL + 1)
                chk({tag, " data_out"}, 32'(data_out), 32'(arr[(e <= TOTAL) ? old_sel : new_sel][e]));
            drive(k);
            cal_start = (k == extra);
        end
        cal_start = 1'b0;
        exp_sel = new_sel;
        // Post-lock steering with fresh random words on every bus.
        for (int i = 0; i < 3; i++) begin
            data0 = 8'($urandom); data90 = 8'($urandom);
            data180 = (i == 0) ? 8'h3C : 8'($urandom); data270 = 8'($urandom);
            @(negedge clk_0);
            chk({tag, " steer"}, 32'(data_out),
                32'((exp_sel == 2'd0) ? data0 : (exp_sel == 2'd1) ? data90 :
                    (exp_sel == 2'd2) ? data180 : data270));
        end
    endtask

    task automatic set_cfg(input int t0, input int t1, input int t2, input int t3);
        typ[0] = t0; typ[1] = t1; typ[2] = t2; typ[3] = t3;
        for (int p = 0; p < 4; p++) begin
            cval[p] = 8'($urandom);
            cpos[p] = int'($urandom_range(1, N - 1));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk_0);
        chk("reset data_out", 32'(data_out), 0);
        chk("reset phase_sel", 32'(phase_sel), 0);
        chk("reset valid_mask", 32'(valid_mask), 0);
        chk("reset flags", {busy, cal_done, cal_fail}, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_0);
        chk("idle flags", {busy, cal_done, cal_fail}, 0);

        set_cfg(0, 0, 0, 0);
        run_cal("all_clean", -1);

        set_cfg(1, 0, 0, 0);
        cval[0] = 8'h57; cpos[0] = N / 2;
        run_cal("ph0_corrupt", -1);

        set_cfg(2, 3, 3, 0);
        run_cal("fallback", -1);

        set_cfg(3, 3, 3, 3);
        run_cal("all_stuck", -1);

        set_cfg(0, 0, 0, 0);
        run_cal("reset_mid", 300);
        set_cfg(0, 1, 0, 0);
        run_cal("after_reset", -1);

        for (int r = 0; r < 4; r++) begin
            set_cfg(($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3)),
                    ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3)),
                    ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3)),
                    ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3)));
            run_cal($sformatf("rand%0d", r), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
